// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory responder and the core's fetch side.
package imem_pkg;

  localparam int INSTR_W = 32;
  localparam int XLEN    = 64;

  // addi x0,x0,0 -- returned in place of a faulting fetch
  localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic {
    IMEM_LOAD = 1'b0,
    IMEM_RUN  = 1'b1
  } imem_state_e;

endpackage

// File: rtl/imem_ram.sv
// Instruction storage: one synchronous write port and one registered read port,
// shaped so synthesis maps it onto a block RAM.
module imem_ram #(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned DATA_W = 32,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata_p1;

  // Write on we, read on re; rdata holds between reads.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
    if (re) begin
      r_rdata_p1 <= r_mem[raddr];
    end
  end

  assign rdata = r_rdata_p1;

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: the program is written in during LOAD, then
// fetches are answered one cycle later in RUN, with misaligned or out-of-range
// PCs answered by a NOP and a fault flag instead of a memory read.
module imem_responder
  import imem_pkg::*;
#(
  parameter int unsigned         DEPTH     = 1024,
  parameter logic [XLEN-1:0]     BASE_ADDR = 64'h0,
  parameter logic [INSTR_W-1:0]  NOP_WORD  = imem_pkg::NOP_WORD
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [INSTR_W-1:0]       load_data,
  input  logic                     load_done,
  input  logic                     fetch_valid,
  input  logic [XLEN-1:0]          fetch_pc,
  output logic                     resp_valid,
  output logic [INSTR_W-1:0]       resp_instruction,
  output logic                     resp_fault,
  output logic                     running
);

  localparam int unsigned     AW    = $clog2(DEPTH);
  localparam logic [XLEN-3:0] WORDS = (XLEN-2)'(DEPTH);

  // Byte offset from the base; a PC below the base wraps to a huge offset and
  // therefore lands in the out-of-range case.
  function automatic logic [XLEN-1:0] f_offset(input logic [XLEN-1:0] pc);
    return pc - BASE_ADDR;
  endfunction

  function automatic logic f_fault(input logic [XLEN-1:0] off);
    return (off[1:0] != 2'b00) || (off[XLEN-1:2] >= WORDS);
  endfunction

  imem_state_e        r_state;
  logic               r_vld_p1;
  logic               r_flt_p1;
  logic               r_use_ram_p1;

  logic [XLEN-1:0]    w_off;
  logic               w_fault;
  logic               w_take;
  logic               w_we;
  logic               w_re;
  logic [AW-1:0]      w_ridx;
  logic [INSTR_W-1:0] w_rdata;

  assign w_off   = f_offset(fetch_pc);
  assign w_fault = f_fault(w_off);
  assign w_ridx  = w_off[AW+1:2];

  // Writes only while loading; fetches only while running, and a faulting
  // fetch never touches the RAM so its output keeps the last good word.
  assign w_we   = (r_state == IMEM_LOAD) && load_valid;
  assign w_take = (r_state == IMEM_RUN) && fetch_valid;
  assign w_re   = w_take && !w_fault;

  // ---- stage p0 -> p1: fetch accepted, RAM read in flight ----
  imem_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (INSTR_W)
  ) u_ram (
    .clk   (clk),
    .we    (w_we),
    .waddr (load_addr),
    .wdata (load_data),
    .re    (w_re),
    .raddr (w_ridx),
    .rdata (w_rdata)
  );

  // Phase FSM plus the response control that travels alongside the RAM read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IMEM_LOAD;
      r_vld_p1     <= 1'b0;
      r_flt_p1     <= 1'b0;
      r_use_ram_p1 <= 1'b0;
    end else begin
      if ((r_state == IMEM_LOAD) && load_done) begin
        r_state <= IMEM_RUN;
      end
      r_vld_p1 <= w_take;
      r_flt_p1 <= w_take && w_fault;
      // Idle cycles leave the selector alone so the previous word is held.
      if (w_take) begin
        r_use_ram_p1 <= !w_fault;
      end
    end
  end

  // ---- stage p1: response out ----
  assign resp_valid       = r_vld_p1;
  assign resp_fault       = r_flt_p1;
  assign resp_instruction = r_use_ram_p1 ? w_rdata : NOP_WORD;
  assign load_ready       = (r_state == IMEM_LOAD);
  assign running          = (r_state == IMEM_RUN);

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: two instances (base 0 and base 0x1000) share all
// inputs; a word-array model predicts every response from the address rules.
module tb_imem_responder;

  localparam int          DEPTH  = 1024;
  localparam logic [63:0] BASE_A = 64'h0;
  localparam logic [63:0] BASE_B = 64'h1000;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] W0     = 32'h0050_0093;
  localparam logic [31:0] W1     = 32'h0010_8113;
  localparam logic [31:0] W5     = 32'h00A0_0513;
  localparam logic [31:0] W1023  = 32'h0FF0_0FF3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load_valid = 1'b0;
  logic [9:0]  load_addr = '0;
  logic [31:0] load_data = '0;
  logic        load_done = 1'b0;
  logic        fetch_valid = 1'b0;
  logic [63:0] fetch_pc = '0;

  logic        ld_rdy_a, vld_a, flt_a, run_a;
  logic [31:0] ins_a;
  logic        ld_rdy_b, vld_b, flt_b, run_b;
  logic [31:0] ins_b;

  imem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE_A), .NOP_WORD(NOP)) u_dut_a (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(ld_rdy_a),
    .load_addr(load_addr), .load_data(load_data), .load_done(load_done),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .resp_valid(vld_a),
    .resp_instruction(ins_a), .resp_fault(flt_a), .running(run_a));

  imem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE_B), .NOP_WORD(NOP)) u_dut_b (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(ld_rdy_b),
    .load_addr(load_addr), .load_data(load_data), .load_done(load_done),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .resp_valid(vld_b),
    .resp_instruction(ins_b), .resp_fault(flt_b), .running(run_b));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- reference model ----------------
  logic [31:0] m_mem [DEPTH];
  bit          m_run;
  logic        e_vld;
  logic [31:0] e_ins_a, e_ins_b;
  logic        e_flt_a, e_flt_b;

  function automatic void ref_fetch(input logic [63:0] pc, input logic [63:0] base,
                                    output logic [31:0] ins, output logic flt);
    logic [63:0] off;
    off = pc - base;
    if ((off % 4) != 0 || (off / 4) >= 64'(DEPTH)) begin
      flt = 1'b1;
      ins = NOP;
    end else begin
      flt = 1'b0;
      ins = m_mem[off / 4];
    end
  endfunction

  task automatic model_reset();
    m_run = 0; e_vld = 0; e_flt_a = 0; e_flt_b = 0; e_ins_a = NOP; e_ins_b = NOP;
  endtask

  // Predict the outputs after the next clock edge from the inputs now applied.
  task automatic model_edge();
    if (!m_run) begin
      if (load_valid) m_mem[load_addr] = load_data;
      e_vld = 0; e_flt_a = 0; e_flt_b = 0;
      if (load_done) m_run = 1;
    end else begin
      e_vld = fetch_valid;
      if (fetch_valid) begin
        ref_fetch(fetch_pc, BASE_A, e_ins_a, e_flt_a);
        ref_fetch(fetch_pc, BASE_B, e_ins_b, e_flt_b);
      end else begin
        e_flt_a = 0; e_flt_b = 0;
      end
    end
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic step_check(input string tag);
    model_edge();
    cyc();
    chk({tag, " vld_a"}, vld_a, e_vld);
    chk({tag, " vld_b"}, vld_b, e_vld);
    chk({tag, " ins_a"}, ins_a, e_ins_a);
    chk({tag, " ins_b"}, ins_b, e_ins_b);
    chk({tag, " flt_a"}, flt_a, e_flt_a);
    chk({tag, " flt_b"}, flt_b, e_flt_b);
    chk({tag, " running"}, run_a, m_run);
    chk({tag, " load_ready"}, ld_rdy_b, !m_run);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    @(posedge clk);
    #3 rst = 1'b0;
  endtask

  function automatic logic [63:0] rand_pc();
    logic [63:0] pc;
    case ($urandom_range(0, 5))
      0: pc = BASE_A + 64'($urandom_range(0, DEPTH - 1)) * 4;
      1: pc = BASE_B + 64'($urandom_range(0, DEPTH - 1)) * 4;
      2: pc = 64'($urandom_range(0, 16'hFFFF));
      3: pc = 64'h2000 + 64'($urandom_range(0, 255));
      4: pc = {$urandom, $urandom};
      default: pc = ($urandom_range(0, 1) != 0 ? 64'h0FF0 : 64'h1FF0) + 64'($urandom_range(0, 31));
    endcase
    return pc;
  endfunction

  typedef struct {
    logic [63:0] pc;
    logic [31:0] ins_a;
    logic        flt_a;
    logic [31:0] ins_b;
    logic        flt_b;
  } vec_t;

  vec_t vt [11];

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{64'h0,                  W0,    1'b0, NOP,   1'b1};
    vt[1]  = '{64'h4,                  W1,    1'b0, NOP,   1'b1};
    vt[2]  = '{64'h2,                  NOP,   1'b1, NOP,   1'b1};
    vt[3]  = '{64'hFFC,                W1023, 1'b0, NOP,   1'b1};
    vt[4]  = '{64'h1000,               NOP,   1'b1, W0,    1'b0};
    vt[5]  = '{64'h1FFC,               NOP,   1'b1, W1023, 1'b0};
    vt[6]  = '{64'h2000,               NOP,   1'b1, NOP,   1'b1};
    vt[7]  = '{64'h14,                 W5,    1'b0, NOP,   1'b1};
    vt[8]  = '{64'h1006,               NOP,   1'b1, NOP,   1'b1};
    vt[9]  = '{64'hFFFF_FFFF_FFFF_FFFC, NOP,  1'b1, NOP,   1'b1};
    vt[10] = '{64'h1004,               NOP,   1'b1, W1,    1'b0};

    // Reset state, checked before any clock edge
    #1 rst = 1'b1;
    #2;
    chk("reset vld", vld_a, 1'b0);
    chk("reset ins", ins_a, NOP);
    chk("reset flt", flt_a, 1'b0);
    chk("reset running", run_a, 1'b0);
    chk("reset load_ready", ld_rdy_a, 1'b1);
    model_reset();
    @(posedge clk);
    #3 rst = 1'b0;

    // Fetches during LOAD are ignored
    fetch_valid = 1'b1; fetch_pc = 64'h0;
    step_check("load-fetch");
    step_check("load-fetch");
    fetch_valid = 1'b0;

    // Fill the whole memory
    for (int i = 0; i < DEPTH; i++) begin
      load_valid = 1'b1;
      load_addr  = 10'(i);
      case (i)
        0:       load_data = W0;
        1:       load_data = W1;
        5:       load_data = W5;
        1023:    load_data = W1023;
        default: load_data = $urandom;
      endcase
      step_check("load");
    end
    load_valid = 1'b0;
    load_done  = 1'b1;
    step_check("done");
    load_done  = 1'b0;

    // Table vectors issued back to back
    for (int i = 0; i < 11; i++) begin
      fetch_valid = 1'b1;
      fetch_pc    = vt[i].pc;
      model_edge();
      cyc();
      chk($sformatf("vec%0d vld", i), vld_a, 1'b1);
      chk($sformatf("vec%0d ins_a", i), ins_a, vt[i].ins_a);
      chk($sformatf("vec%0d flt_a", i), flt_a, vt[i].flt_a);
      chk($sformatf("vec%0d ins_b", i), ins_b, vt[i].ins_b);
      chk($sformatf("vec%0d flt_b", i), flt_b, vt[i].flt_b);
    end
    fetch_valid = 1'b0;
    step_check("hold");
    step_check("hold");

    // Loads in RUN are dropped
    load_valid = 1'b1; load_addr = 10'd0; load_data = 32'hDEAD_BEEF;
    chk("run load_ready", ld_rdy_a, 1'b0);
    step_check("run-load");
    load_valid = 1'b0;
    fetch_valid = 1'b1; fetch_pc = 64'h0;
    step_check("run-load-fetch");
    chk("run-load word0", ins_a, W0);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      fetch_valid = ($urandom_range(0, 9) < 7);
      fetch_pc    = rand_pc();
      load_valid  = $urandom_range(0, 1);
      load_addr   = 10'($urandom);
      load_data   = $urandom;
      step_check("rand");
    end
    load_valid = 1'b0;

    // Asynchronous reset with a response on the outputs
    fetch_valid = 1'b1; fetch_pc = 64'h4;
    step_check("pre-rst");
    chk("pre-rst vld", vld_a, 1'b1);
    fetch_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async-rst vld", vld_a, 1'b0);
    chk("async-rst running", run_a, 1'b0);
    chk("async-rst ins", ins_a, NOP);
    chk("async-rst load_ready", ld_rdy_a, 1'b1);
    model_reset();
    @(posedge clk);
    #3 rst = 1'b0;
    load_done = 1'b1;
    step_check("reload-done");
    load_done = 1'b0;
    fetch_valid = 1'b1; fetch_pc = 64'h0;
    step_check("retained");
    chk("retained word0", ins_a, W0);
    fetch_valid = 1'b0;

    // Write together with load_done
    do_reset();
    load_valid = 1'b1; load_addr = 10'd5; load_data = 32'h0000_0073; load_done = 1'b1;
    step_check("wr+done");
    chk("wr+done running", run_a, 1'b1);
    load_valid = 1'b0; load_done = 1'b0;
    fetch_valid = 1'b1; fetch_pc = 64'h14;
    step_check("wr+done fetch");
    chk("wr+done word5", ins_a, 32'h0000_0073);
    fetch_pc = 64'h1014;
    step_check("wr+done fetch b");
    chk("wr+done word5 b", ins_b, 32'h0000_0073);
    fetch_valid = 1'b0;
    step_check("tail");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
